// File: rtl/ram_io_ctrl_pkg.sv
// rtl/ram_io_ctrl_pkg.sv - shared types and address helpers for the data RAM / I/O window
package cpu15_mem_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_OUT,
    REG_IN,
    REG_STAT,
    REG_NONE
  } region_t;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_IDLE
  } state_t;

  // Address of output port k.
  function automatic int out_addr(int io_base, int k);
    return io_base + k;
  endfunction

  // Address of input port k; inputs follow the output ports.
  function automatic int in_addr(int io_base, int n_out, int k);
    return io_base + n_out + k;
  endfunction

  // Address of the input status word, just after the last input port.
  function automatic int stat_addr(int io_base, int n_out, int n_in);
    return io_base + n_out + n_in;
  endfunction

endpackage

// File: rtl/ram_io_ctrl_io_in_chan.sv
// rtl/ram_io_ctrl_io_in_chan.sv - one input port: holding register plus sticky valid flag
module io_in_chan #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] hold,
  output logic              flag
);

  // Capture on vld; a read clears the flag unless a new capture lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      flag <= 1'b0;
    end else begin
      if (vld) begin
        hold <= din;
        flag <= 1'b1;
      end else if (clr) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_io_ctrl.sv
// rtl/ram_io_ctrl.sv - single-clock data RAM with memory-mapped output/input ports
module ram_io_ctrl
  import cpu15_mem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int RAM_DEPTH = 64,
  parameter int IO_BASE   = 64,
  parameter int N_OUT     = 1,
  parameter int N_IN      = 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  output logic                    READY,
  input  logic                    RD_EN,
  input  logic                    WR_EN,
  input  logic [ADDR_W-1:0]       ADDR,
  input  logic [DATA_W-1:0]       WDATA,
  output logic [DATA_W-1:0]       RDATA,
  output logic                    RVALID,
  output logic [N_OUT*DATA_W-1:0] IO_OUT,
  output logic [N_OUT-1:0]        IO_OUT_STB,
  input  logic [N_IN*DATA_W-1:0]  IO_IN,
  input  logic [N_IN-1:0]         IO_IN_VLD
);

  localparam int                RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] RAM_LIM = ADDR_W'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] STAT_A  = ADDR_W'(stat_addr(IO_BASE, N_OUT, N_IN));
  localparam logic [RAM_AW-1:0] CNT_LAST = RAM_AW'(RAM_DEPTH - 1);

  state_t            state;
  logic [RAM_AW-1:0] init_cnt;
  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] out_q [N_OUT];
  logic [DATA_W-1:0] hold [N_IN];
  logic [N_IN-1:0]   flag;

  region_t           region;
  logic [N_OUT-1:0]  out_hit;
  logic [N_IN-1:0]   in_hit;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] rd_mux;

  assign READY  = (state == ST_IDLE);
  assign rd_acc = READY & RD_EN;
  assign wr_acc = READY & WR_EN;

  // Classify the address into a region and a one-hot port select.
  always_comb begin
    region  = REG_NONE;
    out_hit = '0;
    in_hit  = '0;
    if (ADDR < RAM_LIM) begin
      region = REG_RAM;
    end else if (ADDR == STAT_A) begin
      region = REG_STAT;
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (ADDR == ADDR_W'(out_addr(IO_BASE, k))) begin
        region     = REG_OUT;
        out_hit[k] = 1'b1;
      end
    end
    for (int k = 0; k < N_IN; k++) begin
      if (ADDR == ADDR_W'(in_addr(IO_BASE, N_OUT, k))) begin
        region    = REG_IN;
        in_hit[k] = 1'b1;
      end
    end
  end

  // Read data select; a concurrent write to RAM or an output port is forwarded.
  always_comb begin
    rd_mux = '0;
    case (region)
      REG_RAM:  rd_mux = wr_acc ? WDATA : mem[ADDR[RAM_AW-1:0]];
      REG_OUT: begin
        for (int k = 0; k < N_OUT; k++) begin
          if (out_hit[k]) rd_mux = wr_acc ? WDATA : out_q[k];
        end
      end
      REG_IN: begin
        for (int k = 0; k < N_IN; k++) begin
          if (in_hit[k]) rd_mux = hold[k];
        end
      end
      REG_STAT: rd_mux = DATA_W'(flag);
      default:  rd_mux = '0;
    endcase
  end

  // Init walk: clear one RAM word per cycle, then sit in IDLE until reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == CNT_LAST) begin
        state    <= ST_IDLE;
        init_cnt <= '0;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // RAM array: cleared by the walk, otherwise written by accepted RAM-region writes.
  always_ff @(posedge CLK) begin
    if (state == ST_INIT) begin
      mem[init_cnt] <= '0;
    end else if (wr_acc && region == REG_RAM) begin
      mem[ADDR[RAM_AW-1:0]] <= WDATA;
    end
  end

  // Output port registers and their one-cycle write strobes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      IO_OUT_STB <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (wr_acc && out_hit[k]) out_q[k] <= WDATA;
      end
      IO_OUT_STB <= wr_acc ? out_hit : '0;
    end
  end

  // Registered read response; RDATA holds between reads.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RDATA  <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= rd_acc;
      if (rd_acc) RDATA <= rd_mux;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_OUT; g++) begin : g_out
      assign IO_OUT[g*DATA_W +: DATA_W] = out_q[g];
    end
    for (g = 0; g < N_IN; g++) begin : g_in
      io_in_chan #(.DATA_W(DATA_W)) u_chan (
        .clk   (CLK),
        .rst_n (RESET_N),
        .vld   (IO_IN_VLD[g]),
        .din   (IO_IN[g*DATA_W +: DATA_W]),
        .clr   (rd_acc & in_hit[g]),
        .hold  (hold[g]),
        .flag  (flag[g])
      );
    end
  endgenerate

endmodule

// File: doc/ram_io_ctrl.md
Name: ram_io_ctrl

Overview:
Parametrised single-clock data memory with a memory-mapped I/O window for the CPU data path. It replaces the split decode/write-back-clocked data RAM with one clock and explicit read/write enables. It supports N_OUT output ports and N_IN input ports; each input port has capture-on-valid holding registers and a sticky status flag. After reset it clears the RAM array with a hardware walk; it accepts accesses only once that walk is complete.

Parameters:
DATA_W, 16, data word width
ADDR_W, 8, address width
RAM_DEPTH, 64, RAM words at addresses 0..RAM_DEPTH-1; must satisfy RAM_DEPTH <= IO_BASE
IO_BASE, 64, first I/O address; output ports at IO_BASE+k (k<N_OUT)
N_OUT, 1, output port count (1..8)
N_IN, 1, input port count (1..8); inputs at IO_BASE+N_OUT+k, status at IO_BASE+N_OUT+N_IN (must be < 2^ADDR_W)

Ports:
CLK  in  1  single system clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
READY  out  1  high when init walk is done and accesses are accepted
RD_EN  in  1  read request, sampled when READY
WR_EN  in  1  write request, sampled when READY
ADDR  in  ADDR_W  shared read/write address
WDATA  in  DATA_W  write data
RDATA  out  DATA_W  registered read data
RVALID  out  1  one-cycle pulse, RDATA valid
IO_OUT  out  N_OUT*DATA_W  output port registers, port k at bits [k*DATA_W +: DATA_W]
IO_OUT_STB  out  N_OUT  one-cycle pulse on the cycle after port k is written
IO_IN  in  N_IN*DATA_W  input port data, same packing
IO_IN_VLD  in  N_IN  capture strobe per input port

Behaviour:
- Reset (async assert, sync release): state=INIT, init counter=0, READY=0, RDATA=0, RVALID=0, IO_OUT=0, IO_OUT_STB=0, holding regs=0, status flags=0.
- FSM INIT: writes 0 to ram[counter] each cycle. Counter wraps to IDLE after RAM_DEPTH-1, so exactly RAM_DEPTH cycles. READY goes high on the cycle after the last clear. RD_EN/WR_EN are ignored in INIT (no RVALID, no write).
- FSM IDLE: READY=1; stays until RESET_N is asserted. Reset mid-INIT restarts the walk from 0.
- Read latency 1: when RD_EN is accepted at edge N, RDATA/RVALID update at edge N. RVALID is high exactly one cycle per accepted read. RDATA holds its last value otherwise.
- Read decode:
  - RAM region: array word.
  - Output port k: current IO_OUT[k].
  - Input k: holding reg k.
  - Status: bit k = flag k, upper bits 0.
  - Unmapped address (RAM_DEPTH..IO_BASE-1, above status): returns 0 with RVALID=1.
- Write decode:
  - RAM region: updates the array.
  - Output port k: updates IO_OUT[k] and pulses IO_OUT_STB[k] for the following cycle.
  - Input, status and unmapped addresses: write ignored.
- Simultaneous RD_EN and WR_EN to the same address: write-first, RDATA returns WDATA (RAM and output ports).
- Input capture: IO_IN_VLD[k]=1 loads holding reg k and sets flag k, independent of READY (also active during INIT).
- Reading input k clears flag k. If IO_IN_VLD[k] occurs in the same cycle: RDATA returns the old holding value, the reg loads the new value, and the flag stays set (set wins).
- Back-to-back accesses every cycle are supported with no stalls.

Decomposition:
- Package cpu15_mem_pkg:
  - region enum {REG_RAM, REG_OUT, REG_IN, REG_STAT, REG_NONE};
  - FSM state enum {ST_INIT, ST_IDLE};
  - localparam helpers for address bases.
- Sub-module io_in_chan: one holding register plus sticky flag with capture/clear priority. Instantiated N_IN times via generate.

Test Plan:
1. Release reset; count cycles -> READY rises after exactly 64 cycles; reads of addr 0 and 63 then return 0x0000 with RVALID for one cycle.
2. Write 0xBEEF to addr 5, next cycle read 5 -> RDATA=0xBEEF one cycle later. Same-cycle RD+WR of 0x1234 to addr 7 -> RDATA=0x1234.
3. Write 0x00A5 to addr 64 -> IO_OUT=0x00A5 and IO_OUT_STB=1 for exactly one cycle. Read 64 -> 0x00A5. Write to addr 70 -> no state change; read 70 -> 0x0000.
4. IO_IN=0x5A5A with IO_IN_VLD pulse -> read 66 = 0x0001. Read 65 = 0x5A5A. Read 66 again = 0x0000.
5. Read 65 in the same cycle as VLD with IO_IN=0x7777 -> RDATA=old value, flag stays 1, next read 65 = 0x7777.
6. Assert RESET_N low mid-INIT (cycle 30) and after writes -> all outputs 0 immediately; walk restarts; READY again after 64 cycles; prior RAM data reads 0.
